// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI period sequencer.
package hdmi_pkg;

    // Data-island-free period sequence used on every active line
    typedef enum logic [1:0] {
        CTRL,
        PREAMBLE,
        GUARD,
        VIDEO
    } period_t;

    // Video guard-band words, loaded in place of the encoder outputs
    localparam logic [9:0] GB_CODE_RED   = 10'b1011001100;
    localparam logic [9:0] GB_CODE_GREEN = 10'b0100110011;
    localparam logic [9:0] GB_CODE_BLUE  = 10'b1011001100;

    // Video preamble control bits: {CTL3,CTL2} on red, {CTL1,CTL0} on green
    localparam logic [1:0] PRE_CTL_RED   = 2'b00;
    localparam logic [1:0] PRE_CTL_GREEN = 2'b01;

    // 720p60 timing defaults
    localparam int unsigned DEF_H_ACTIVE = 1280;
    localparam int unsigned DEF_H_FP     = 110;
    localparam int unsigned DEF_H_SYNC   = 40;
    localparam int unsigned DEF_H_BP     = 220;
    localparam int unsigned DEF_V_ACTIVE = 720;
    localparam int unsigned DEF_V_FP     = 5;
    localparam int unsigned DEF_V_SYNC   = 5;
    localparam int unsigned DEF_V_BP     = 20;
    localparam int unsigned DEF_PRE_LEN  = 8;
    localparam int unsigned DEF_GB_LEN   = 2;

endpackage

// File: rtl/hdmi_period_sequencer_raster_counter.sv
// Raster position counters with registered sync / active-draw decode.
// The next-cycle position and sync bits are also exported so the top can
// register its own flags coherently with the counters.
module raster_counter
    import hdmi_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned PRE_LEN  = DEF_PRE_LEN,
    parameter int unsigned GB_LEN   = DEF_GB_LEN
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [10:0] o_hcount,
    output logic [9:0]  o_vcount,
    output logic [10:0] o_hcount_next,
    output logic [9:0]  o_vcount_next,
    output logic        o_hs_next,
    output logic        o_vs_next,
    output logic        o_ad,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_new_frame
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    // Reset parks one clock before the preamble of the last line
    localparam logic [10:0] H_RESET      = 11'(H_TOTAL - PRE_LEN - GB_LEN - 1);
    localparam logic [10:0] H_ACT        = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT        = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] r_hcount;
    logic [9:0]  r_vcount;
    logic        r_ad;
    logic        r_hs;
    logic        r_vs;
    logic        r_new_frame;

    logic [10:0] w_hcount_next;
    logic [9:0]  w_vcount_next;
    logic        w_hs_next;
    logic        w_vs_next;
    logic        w_ad_next;
    logic        w_new_frame_next;

    // Next raster position and the flags that will describe it
    always_comb begin
        w_hcount_next = (r_hcount == H_LAST) ? 11'd0 : r_hcount + 11'd1;
        w_vcount_next = r_vcount;
        if (r_hcount == H_LAST) begin
            w_vcount_next = (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
        end
        w_hs_next        = (w_hcount_next >= H_SYNC_FIRST) && (w_hcount_next <= H_SYNC_LAST);
        w_vs_next        = (w_vcount_next >= V_SYNC_FIRST) && (w_vcount_next <= V_SYNC_LAST);
        w_ad_next        = (w_hcount_next < H_ACT) && (w_vcount_next < V_ACT);
        w_new_frame_next = (w_hcount_next == 11'd0) && (w_vcount_next == 10'd0);
    end

    // Counter and flag registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hcount    <= H_RESET;
            r_vcount    <= V_LAST;
            r_ad        <= 1'b0;
            r_hs        <= 1'b0;
            r_vs        <= 1'b0;
            r_new_frame <= 1'b0;
        end else begin
            r_hcount    <= w_hcount_next;
            r_vcount    <= w_vcount_next;
            r_ad        <= w_ad_next;
            r_hs        <= w_hs_next;
            r_vs        <= w_vs_next;
            r_new_frame <= w_new_frame_next;
        end
    end

    assign o_hcount      = r_hcount;
    assign o_vcount      = r_vcount;
    assign o_hcount_next = w_hcount_next;
    assign o_vcount_next = w_vcount_next;
    assign o_hs_next     = w_hs_next;
    assign o_vs_next     = w_vs_next;
    assign o_ad          = r_ad;
    assign o_hs          = r_hs;
    assign o_vs          = r_vs;
    assign o_new_frame   = r_new_frame;

endmodule

// File: rtl/hdmi_period_sequencer.sv
// Period sequencer for three TMDS channels: raster timing, control/preamble/
// guard/video FSM, and the guard-band mux in front of the serializers.
module hdmi_period_sequencer
    import hdmi_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned PRE_LEN  = DEF_PRE_LEN,
    parameter int unsigned GB_LEN   = DEF_GB_LEN
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [9:0]  tmds_red_in,
    input  logic [9:0]  tmds_green_in,
    input  logic [9:0]  tmds_blue_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        ad_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        new_frame_out,
    output logic        ve_out,
    output logic [1:0]  ctrl_red_out,
    output logic [1:0]  ctrl_green_out,
    output logic [1:0]  ctrl_blue_out,
    output logic        gb_out,
    output logic [9:0]  tmds_red_out,
    output logic [9:0]  tmds_green_out,
    output logic [9:0]  tmds_blue_out
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_PRE_START = 11'(H_TOTAL - PRE_LEN - GB_LEN);
    localparam logic [10:0] H_GB_START  = 11'(H_TOTAL - GB_LEN);
    localparam logic [10:0] H_ACT       = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT_M1    = 10'(V_ACTIVE - 1);

    logic [10:0] w_hcount_next;
    logic [9:0]  w_vcount_next;
    logic        w_hs_next;
    logic        w_vs_next;
    logic        w_next_line_active;

    period_t     r_state;
    period_t     w_state_d;
    logic        w_ve_d;
    logic        w_gb_d;
    logic [1:0]  w_ctrl_red_d;
    logic [1:0]  w_ctrl_green_d;
    logic [1:0]  w_ctrl_blue_d;

    logic        r_ve;
    logic        r_gb;
    logic [1:0]  r_ctrl_red;
    logic [1:0]  r_ctrl_green;
    logic [1:0]  r_ctrl_blue;
    logic        r_gb_dly;
    logic [9:0]  r_tmds_red;
    logic [9:0]  r_tmds_green;
    logic [9:0]  r_tmds_blue;

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .PRE_LEN  (PRE_LEN),
        .GB_LEN   (GB_LEN)
    ) u_raster (
        .i_clk         (clk_in),
        .i_rst         (rst_in),
        .o_hcount      (hcount_out),
        .o_vcount      (vcount_out),
        .o_hcount_next (w_hcount_next),
        .o_vcount_next (w_vcount_next),
        .o_hs_next     (w_hs_next),
        .o_vs_next     (w_vs_next),
        .o_ad          (ad_out),
        .o_hs          (hs_out),
        .o_vs          (vs_out),
        .o_new_frame   (new_frame_out)
    );

    // The line following the next-cycle line carries video: (v+1) mod V_TOTAL < V_ACTIVE
    assign w_next_line_active = (w_vcount_next == V_LAST) || (w_vcount_next < V_ACT_M1);

    // Next period and its encoder controls, evaluated against the next raster position
    // so the registered flags line up with the registered counters
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            CTRL: begin
                if ((w_hcount_next == H_PRE_START) && w_next_line_active) begin
                    w_state_d = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (w_hcount_next == H_GB_START) begin
                    w_state_d = GUARD;
                end
            end
            GUARD: begin
                if (w_hcount_next == 11'd0) begin
                    w_state_d = VIDEO;
                end
            end
            VIDEO: begin
                if (w_hcount_next == H_ACT) begin
                    w_state_d = CTRL;
                end
            end
            default: w_state_d = CTRL;
        endcase

        w_ve_d         = 1'b0;
        w_gb_d         = 1'b0;
        w_ctrl_red_d   = 2'b00;
        w_ctrl_green_d = 2'b00;
        w_ctrl_blue_d  = {w_vs_next, w_hs_next};
        unique case (w_state_d)
            PREAMBLE: begin
                w_ctrl_red_d   = PRE_CTL_RED;
                w_ctrl_green_d = PRE_CTL_GREEN;
            end
            GUARD: begin
                w_ctrl_red_d   = PRE_CTL_RED;
                w_ctrl_green_d = PRE_CTL_GREEN;
                w_gb_d         = 1'b1;
            end
            VIDEO: begin
                w_ve_d        = 1'b1;
                w_ctrl_blue_d = 2'b00;
            end
            default: ;
        endcase
    end

    // Period state and registered encoder controls
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= CTRL;
            r_ve         <= 1'b0;
            r_gb         <= 1'b0;
            r_ctrl_red   <= 2'b00;
            r_ctrl_green <= 2'b00;
            r_ctrl_blue  <= 2'b00;
        end else begin
            r_state      <= w_state_d;
            r_ve         <= w_ve_d;
            r_gb         <= w_gb_d;
            r_ctrl_red   <= w_ctrl_red_d;
            r_ctrl_green <= w_ctrl_green_d;
            r_ctrl_blue  <= w_ctrl_blue_d;
        end
    end

    // Guard flag delayed one clock to match encoder latency, then the output mux
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_gb_dly     <= 1'b0;
            r_tmds_red   <= 10'd0;
            r_tmds_green <= 10'd0;
            r_tmds_blue  <= 10'd0;
        end else begin
            r_gb_dly     <= r_gb;
            r_tmds_red   <= r_gb_dly ? GB_CODE_RED   : tmds_red_in;
            r_tmds_green <= r_gb_dly ? GB_CODE_GREEN : tmds_green_in;
            r_tmds_blue  <= r_gb_dly ? GB_CODE_BLUE  : tmds_blue_in;
        end
    end

    assign ve_out         = r_ve;
    assign gb_out         = r_gb;
    assign ctrl_red_out   = r_ctrl_red;
    assign ctrl_green_out = r_ctrl_green;
    assign ctrl_blue_out  = r_ctrl_blue;
    assign tmds_red_out   = r_tmds_red;
    assign tmds_green_out = r_tmds_green;
    assign tmds_blue_out  = r_tmds_blue;

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// Scoreboard bench for hdmi_period_sequencer on a shrunken raster so that many
// full frames, random resets and directed mid-line resets fit in a short run.
module tb_hdmi_period_sequencer;

    localparam int unsigned HA  = 16;
    localparam int unsigned HFP = 4;
    localparam int unsigned HS  = 3;
    localparam int unsigned HBP = 12;
    localparam int unsigned VA  = 6;
    localparam int unsigned VFP = 2;
    localparam int unsigned VS  = 2;
    localparam int unsigned VBP = 3;
    localparam int unsigned PRE = 8;
    localparam int unsigned GB  = 2;

    localparam int unsigned HT    = HA + HFP + HS + HBP;
    localparam int unsigned VT    = VA + VFP + VS + VBP;
    localparam int unsigned FRAME = HT * VT;
    // Raster position (linear index v*HT+h) that reset loads
    localparam int unsigned P_RST   = (VT - 1) * HT + (HT - PRE - GB - 1);
    // Directed resets: mid-video and first guard cycle
    localparam int unsigned P_MID   = 3 * HT + 8;
    localparam int unsigned P_GBRST = 2 * HT + (HT - GB);
    localparam int unsigned N_CYCLES = 6000;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        ad;
        logic        hs;
        logic        vs;
        logic        nf;
        logic        ve;
        logic        gb;
        logic [1:0]  c_red;
        logic [1:0]  c_grn;
        logic [1:0]  c_blu;
        logic [9:0]  t_red;
        logic [9:0]  t_grn;
        logic [9:0]  t_blu;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [9:0]  tmds_red_in;
    logic [9:0]  tmds_green_in;
    logic [9:0]  tmds_blue_in;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        ad_out;
    logic        hs_out;
    logic        vs_out;
    logic        new_frame_out;
    logic        ve_out;
    logic [1:0]  ctrl_red_out;
    logic [1:0]  ctrl_green_out;
    logic [1:0]  ctrl_blue_out;
    logic        gb_out;
    logic [9:0]  tmds_red_out;
    logic [9:0]  tmds_green_out;
    logic [9:0]  tmds_blue_out;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int   m_p;
    logic m_gb;
    logic m_gbd;

    hdmi_period_sequencer #(
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP),
        .PRE_LEN  (PRE),
        .GB_LEN   (GB)
    ) u_dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .tmds_red_in    (tmds_red_in),
        .tmds_green_in  (tmds_green_in),
        .tmds_blue_in   (tmds_blue_in),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .ad_out         (ad_out),
        .hs_out         (hs_out),
        .vs_out         (vs_out),
        .new_frame_out  (new_frame_out),
        .ve_out         (ve_out),
        .ctrl_red_out   (ctrl_red_out),
        .ctrl_green_out (ctrl_green_out),
        .ctrl_blue_out  (ctrl_blue_out),
        .gb_out         (gb_out),
        .tmds_red_out   (tmds_red_out),
        .tmds_green_out (tmds_green_out),
        .tmds_blue_out  (tmds_blue_out)
    );

    initial forever #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs after the coming edge, from the raster rules directly
    task automatic push_expect();
        exp_t e;
        int   h;
        int   v;
        bit   next_act;
        bit   pre;
        bit   grd;
        bit   vid;
        e = '0;
        if (rst_in) begin
            m_p   = P_RST;
            e.h   = 11'(P_RST % HT);
            e.v   = 10'(P_RST / HT);
            m_gb  = 1'b0;
            m_gbd = 1'b0;
        end else begin
            m_p      = (m_p + 1) % FRAME;
            h        = m_p % HT;
            v        = m_p / HT;
            next_act = ((v + 1) % VT) < VA;
            pre      = next_act && (h >= HT - PRE - GB) && (h < HT - GB);
            grd      = next_act && (h >= HT - GB);
            vid      = (h < HA) && (v < VA);
            e.h      = 11'(h);
            e.v      = 10'(v);
            e.ad     = vid;
            e.hs     = (h >= HA + HFP) && (h < HA + HFP + HS);
            e.vs     = (v >= VA + VFP) && (v < VA + VFP + VS);
            e.nf     = (h == 0) && (v == 0);
            e.ve     = vid;
            e.gb     = grd;
            e.c_red  = 2'b00;
            e.c_grn  = (pre || grd) ? 2'b01 : 2'b00;
            e.c_blu  = vid ? 2'b00 : {e.vs, e.hs};
            e.t_red  = m_gbd ? 10'b1011001100 : tmds_red_in;
            e.t_grn  = m_gbd ? 10'b0100110011 : tmds_green_in;
            e.t_blu  = m_gbd ? 10'b1011001100 : tmds_blue_in;
            m_gbd    = m_gb;
            m_gb     = grd;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare every presented output word against the scoreboard
    initial begin
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("hcount", 32'(hcount_out), 32'(mon_e.h));
                check("vcount", 32'(vcount_out), 32'(mon_e.v));
                check("ad", 32'(ad_out), 32'(mon_e.ad));
                check("hs", 32'(hs_out), 32'(mon_e.hs));
                check("vs", 32'(vs_out), 32'(mon_e.vs));
                check("new_frame", 32'(new_frame_out), 32'(mon_e.nf));
                check("ve", 32'(ve_out), 32'(mon_e.ve));
                check("gb", 32'(gb_out), 32'(mon_e.gb));
                check("ctrl_red", 32'(ctrl_red_out), 32'(mon_e.c_red));
                check("ctrl_green", 32'(ctrl_green_out), 32'(mon_e.c_grn));
                check("ctrl_blue", 32'(ctrl_blue_out), 32'(mon_e.c_blu));
                check("tmds_red", 32'(tmds_red_out), 32'(mon_e.t_red));
                check("tmds_green", 32'(tmds_green_out), 32'(mon_e.t_grn));
                check("tmds_blue", 32'(tmds_blue_out), 32'(mon_e.t_blu));
            end
        end
    end

    // Stimulus: random encoder words, random short resets, two directed resets
    initial begin
        int rst_hold;
        bit did_mid;
        bit did_gb;
        rst_hold      = 0;
        did_mid       = 1'b0;
        did_gb        = 1'b0;
        m_p           = 0;
        m_gb          = 1'b0;
        m_gbd         = 1'b0;
        rst_in        = 1'b1;
        tmds_red_in   = 10'($urandom);
        tmds_green_in = 10'($urandom);
        tmds_blue_in  = 10'($urandom);
        push_expect();
        for (int n = 1; n < N_CYCLES; n++) begin
            @(posedge clk_in);
            #1;
            if (n < 3) begin
                rst_in = 1'b1;
            end else if (rst_hold > 0) begin
                rst_in = 1'b1;
                rst_hold--;
            end else if (!did_mid && m_p == P_MID) begin
                rst_in  = 1'b1;
                did_mid = 1'b1;
            end else if (!did_gb && m_p == P_GBRST) begin
                rst_in = 1'b1;
                did_gb = 1'b1;
            end else if ($urandom_range(0, 799) == 0) begin
                rst_in   = 1'b1;
                rst_hold = $urandom_range(0, 2);
            end else begin
                rst_in = 1'b0;
            end
            tmds_red_in   = 10'($urandom);
            tmds_green_in = 10'($urandom);
            tmds_blue_in  = 10'($urandom);
            push_expect();
        end
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clk_in);
        end
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
